reg_bank_mp: RTL

- Parametrised, multi-read-port successor to the 14 x 16-bit register bank.
- Provides one byte-enabled write port, NUM_RD independent registered read ports, and address-range checking with an error pulse.
- Includes saturating write/error activity counters for bench and status visibility.
- Sits behind the bus/command decoder as the block's architectural register file.

---
 rtl/reg_bank_pkg.sv | 45 ++++
 rtl/reg_bank_rd_port.sv | 74 +++++++
 rtl/reg_bank_mp.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
// Shared definitions for the multi-read-port register bank.
//   DEF_NUM_REGS / DEF_DATA_W : default geometry of the bank
//   byteMerge                 : overlay enabled bytes of a new word onto an old word
//   satInc                    : increment that sticks at all-ones for a given width
// Both helpers work on a fixed 64-bit container, so DATA_W may be at most 64
// and counter widths at most 63. Callers zero-extend into the container and
// truncate the result back to their own width.
package reg_bank_pkg;

    localparam int DEF_NUM_REGS = 14;
    localparam int DEF_DATA_W   = 16;
    localparam int MAX_DATA_W   = 64;
    localparam int MAX_BE_W     = MAX_DATA_W / 8;

    // Byte lane i of the result comes from newVal when be[i] is set, otherwise from oldVal.
    function automatic logic [MAX_DATA_W-1:0] byteMerge(
        input logic [MAX_DATA_W-1:0] oldVal,
        input logic [MAX_DATA_W-1:0] newVal,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = oldVal;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = newVal[i*8 +: 8];
            end
        end
        return merged;
    endfunction

    // Saturates at the all-ones value of the low 'width' bits instead of wrapping.
    function automatic logic [63:0] satInc(
        input logic [63:0] value,
        input int          width
    );
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        if ((value & mask) == mask) begin
            return value;
        end
        return value + 64'd1;
    endfunction

endpackage

// File: rtl/reg_bank_rd_port.sv
// reg_bank_rd_port
// One registered read port of the register bank.
//   clk, rst_n      : clock, asynchronous active-low reset
//   rd_en_i         : read request for this port
//   rd_addr_i       : read address for this port
//   regs_i          : current contents of every register
//   wr_accept_i     : a write is being committed this cycle
//   wr_addr_i       : address of that write
//   wr_merged_i     : post-write value of that register (byte enables applied)
//   rd_data_o       : registered read data, holds when not reading
//   rd_valid_o      : one-cycle valid, one cycle after the request
//   rd_err_o        : combinational flag, this port requests an out-of-range address
module reg_bank_rd_port
    import reg_bank_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] regs_i [NUM_REGS],
    input  logic              wr_accept_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_merged_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_err_o
);

    logic              inRange;
    logic [DATA_W-1:0] rdData_d;
    logic [DATA_W-1:0] rdData_q;
    logic              rdValid_q;

    // Select the addressed register, substituting the in-flight write so a
    // same-cycle write and read see the new value. The one-bit-wider compare
    // keeps the range check correct when NUM_REGS == 2**ADDR_W.
    always_comb begin
        inRange  = ({1'b0, rd_addr_i} < (ADDR_W+1)'(NUM_REGS));
        rdData_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_i == ADDR_W'(i)) begin
                rdData_d = regs_i[i];
            end
        end
        if (wr_accept_i && (wr_addr_i == rd_addr_i)) begin
            rdData_d = wr_merged_i;
        end
        if (!inRange) begin
            rdData_d = '0;
        end
    end

    // Data only updates on a request so the last value is held; valid follows the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            rdValid_q <= rd_en_i;
            if (rd_en_i) begin
                rdData_q <= rdData_d;
            end
        end
    end

    assign rd_data_o  = rdData_q;
    assign rd_valid_o = rdValid_q;
    assign rd_err_o   = rd_en_i && !inRange;

endmodule

// File: rtl/reg_bank_mp.sv
// reg_bank_mp
// Architectural register file: one byte-enabled write port, NUM_RD registered
// read ports, out-of-range detection and saturating activity counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data, wr_be : write request, address, data, byte enables
//   rd_en, rd_addr   : per-port read requests and packed addresses
//   rd_data, rd_valid: packed registered read data and per-port valid
//   err              : one-cycle pulse after any cycle with an offending access
//   wr_count, err_count : saturating counts of accepted writes / erroring cycles
// Optional macro REG_BANK_LOCK_EN adds lock_set (input) and locked (output):
// a write with lock_set freezes that register until reset.
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
`ifdef REG_BANK_LOCK_EN
    input  logic                     lock_set,
    output logic [NUM_REGS-1:0]      locked,
`endif
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     err,
    output logic [CNT_W-1:0]         wr_count,
    output logic [CNT_W-1:0]         err_count
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wrInRange;
    logic              wrAttempt;
    logic              wrLockedHit;
    logic              wrAccept;
    logic [DATA_W-1:0] wrCurrent;
    logic [DATA_W-1:0] wrMerged;
    logic [NUM_RD-1:0] rdErr;
    logic              err_d;
    logic              err_q;
    logic [CNT_W-1:0]  wrCount_d;
    logic [CNT_W-1:0]  wrCount_q;
    logic [CNT_W-1:0]  errCount_d;
    logic [CNT_W-1:0]  errCount_q;
`ifdef REG_BANK_LOCK_EN
    logic [NUM_REGS-1:0] locked_q;
`endif

    // Write decode: a write with no byte enables is a pure no-op (no error,
    // no count). The merged word is computed once and shared with every
    // read port for the write-first bypass.
    always_comb begin
        wrInRange   = ({1'b0, wr_addr} < (ADDR_W+1)'(NUM_REGS));
        wrAttempt   = wr_en && (wr_be != '0);
        wrCurrent   = '0;
        wrLockedHit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                wrCurrent = regs_q[i];
`ifdef REG_BANK_LOCK_EN
                wrLockedHit = locked_q[i];
`endif
            end
        end
        wrMerged = DATA_W'(byteMerge(MAX_DATA_W'(wrCurrent), MAX_DATA_W'(wr_data),
                                     MAX_BE_W'(wr_be)));
        wrAccept = wrAttempt && wrInRange && !wrLockedHit;
    end

    // Any offending access in the cycle collapses into one error event.
    always_comb begin
        err_d      = (wrAttempt && !wrInRange) || (wrAttempt && wrInRange && wrLockedHit)
                     || (|rdErr);
        wrCount_d  = wrAccept ? CNT_W'(satInc(64'(wrCount_q), CNT_W)) : wrCount_q;
        errCount_d = err_d ? CNT_W'(satInc(64'(errCount_q), CNT_W)) : errCount_q;
    end

    // Register storage; only the addressed register is written on an accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrAccept && (wr_addr == ADDR_W'(i))) begin
                    regs_q[i] <= wrMerged;
                end
            end
        end
    end

`ifdef REG_BANK_LOCK_EN
    // Lock bits are sticky until reset; the locking write itself still lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrAccept && lock_set && (wr_addr == ADDR_W'(i))) begin
                    locked_q[i] <= 1'b1;
                end
            end
        end
    end

    assign locked = locked_q;
`endif

    // Error pulse and activity counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            wrCount_q  <= '0;
            errCount_q <= '0;
        end else begin
            err_q      <= err_d;
            wrCount_q  <= wrCount_d;
            errCount_q <= errCount_d;
        end
    end

    assign err       = err_q;
    assign wr_count  = wrCount_q;
    assign err_count = errCount_q;

    // One independent read port per packed slice.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        reg_bank_rd_port #(
            .NUM_REGS (NUM_REGS),
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W)
        ) u_rd_port (
            .clk         (clk),
            .rst_n       (rst_n),
            .rd_en_i     (rd_en[p]),
            .rd_addr_i   (rd_addr[p*ADDR_W +: ADDR_W]),
            .regs_i      (regs_q),
            .wr_accept_i (wrAccept),
            .wr_addr_i   (wr_addr),
            .wr_merged_i (wrMerged),
            .rd_data_o   (rd_data[p*DATA_W +: DATA_W]),
            .rd_valid_o  (rd_valid[p]),
            .rd_err_o    (rdErr[p])
        );
    end

endmodule
